// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: captures a cipher key and presents round
// keys 0..10, one per rk_valid/rk_ready handshake, with no key storage beyond the current key.

module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int unsigned i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv = ginv(i_a);
    o_s   = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
          ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_last
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_key;
  logic [3:0]   r_idx;
  logic [7:0]   r_rcon;
  logic         w_load;
  logic         w_adv;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [31:0]  w_n0;
  logic [31:0]  w_n1;
  logic [31:0]  w_n2;
  logic [31:0]  w_n3;
  logic [127:0] w_next_key;
  logic [7:0]   w_rcon_nxt;

  assign w_rot = {r_key[23:0], r_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .i_a (w_rot[8*g +: 8]),
      .o_s (w_sub[8*g +: 8])
    );
  end

  assign w_t        = w_sub ^ {r_rcon, 24'h0};
  assign w_n0       = r_key[127:96] ^ w_t;
  assign w_n1       = r_key[95:64]  ^ w_n0;
  assign w_n2       = r_key[63:32]  ^ w_n1;
  assign w_n3       = r_key[31:0]   ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (rk_ready) begin
          if (r_idx == 4'd10) w_state_nxt = S_IDLE;
          else                w_adv       = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_idx  <= '0;
      r_rcon <= 8'h01;
    end else if (w_load) begin
      r_key  <= key_in;
      r_idx  <= '0;
      r_rcon <= 8'h01;
    end else if (w_adv) begin
      r_key  <= w_next_key;
      r_idx  <= r_idx + 4'd1;
      r_rcon <= w_rcon_nxt;
    end
  end

  assign key_ready = (r_state == S_IDLE);
  assign rk_valid  = (r_state == S_RUN);
  assign rk_last   = rk_valid && (r_idx == 4'd10);
  assign round_key = r_key;
  assign round_idx = r_idx;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 table-driven key expansion model checked every cycle,
// plus directed literal round keys and protocol scenarios.

module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ready;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_last;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  aes_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_ready (key_ready),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_last   (rk_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_K1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_K1     = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_K10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // FIPS-197 word-wise expansion: w[i] = w[i-4] ^ temp, with SubWord/RotWord/Rcon every 4th word.
  function automatic logic [10:0][127:0] expand(input logic [127:0] k);
    logic [31:0]        w [0:43];
    logic [31:0]        t;
    logic [10:0][127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {RCON[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Protocol-level reference: which key index the consumer should be looking at.
  logic               m_run;
  logic [3:0]         m_ri;
  logic [127:0]       m_rk;
  logic [10:0][127:0] m_tab;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_ri  <= '0;
      m_rk  <= '0;
    end else if (!m_run) begin
      if (key_valid) begin
        m_run <= 1'b1;
        m_ri  <= '0;
        m_rk  <= key_in;
        m_tab <= expand(key_in);
      end
    end else if (rk_ready) begin
      if (m_ri == 4'd10) m_run <= 1'b0;
      else begin
        m_ri <= m_ri + 4'd1;
        m_rk <= m_tab[m_ri + 4'd1];
      end
    end
  end

  always @(negedge clk) begin
    chk("key_ready", 128'(key_ready), 128'(!m_run));
    chk("rk_valid",  128'(rk_valid),  128'(m_run));
    chk("round_idx", 128'(round_idx), 128'(m_ri));
    chk("round_key", round_key,       m_rk);
    chk("rk_last",   128'(rk_last),   128'(m_run && m_ri == 4'd10));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!key_ready && n < 100) begin
      tick();
      n++;
    end
    chk({nm, "_idle_timeout"}, 128'(key_ready), 128'(1));
  endtask

  task automatic run_check(input string nm, input logic [127:0] key, input logic [127:0] l1,
                           input logic [127:0] l2, input bit has2, input logic [127:0] l10);
    int n;
    tick();
    chk({nm, "_ready_before"}, 128'(key_ready), 128'(1));
    key_valid = 1'b1;
    key_in    = key;
    tick();
    key_valid = 1'b0;
    key_in    = ~key;
    n = 0;
    while (rk_valid && n < 20) begin
      if (n == 0) chk({nm, "_k0"}, round_key, key);
      if (round_idx == 4'd1) chk({nm, "_k1"}, round_key, l1);
      if (has2 && round_idx == 4'd2) chk({nm, "_k2"}, round_key, l2);
      if (round_idx == 4'd10) begin
        chk({nm, "_k10"}, round_key, l10);
        chk({nm, "_last"}, 128'(rk_last), 128'(1));
      end
      n++;
      tick();
    end
    chk({nm, "_valid_cycles"}, 128'(n), 128'(11));
    chk({nm, "_ready_after"}, 128'(key_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [10:0][127:0] tab;
    int n;
    bit hs;

    tab = expand(KEY_A1);
    chk("model_a1_k1",  tab[1],  A1_K1);
    chk("model_a1_k2",  tab[2],  A1_K2);
    chk("model_a1_k10", tab[10], A1_K10);
    tab = expand('0);
    chk("model_z_k1",   tab[1],  Z_K1);
    chk("model_z_k10",  tab[10], Z_K10);

    #12;
    chk("reset_ready", 128'(key_ready), 128'(1));
    chk("reset_valid", 128'(rk_valid),  128'(0));
    chk("reset_key",   round_key,       128'(0));
    rst_n = 1'b1;

    run_check("a1", KEY_A1, A1_K1, A1_K2, 1'b1, A1_K10);
    run_check("zero", '0, Z_K1, '0, 1'b0, Z_K10);

    // Random consumer stalls on the A.1 key.
    tick();
    key_valid = 1'b1;
    key_in    = KEY_A1;
    tick();
    key_valid = 1'b0;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 400) begin
      rk_ready = 1'($urandom_range(0, 1));
      #1;
      hs = rk_valid && rk_last && rk_ready;
      tick();
      n++;
    end
    chk("stall_done", 128'(hs), 128'(1));
    rk_ready = 1'b1;
    wait_idle("stall");

    // Different key pulsed mid-schedule must be ignored.
    tick();
    key_valid = 1'b1;
    key_in    = KEY_A1;
    tick();
    key_valid = 1'b0;
    tick(); tick(); tick();
    key_valid = 1'b1;
    key_in    = KEY_ALT;
    tick();
    key_valid = 1'b0;
    chk("ignore_idx", 128'(round_idx), 128'(4));
    wait_idle("ignore");

    // Back-to-back: second key held valid while the first schedule runs.
    tick();
    key_valid = 1'b1;
    key_in    = KEY_A1;
    tick();
    chk("b2b_first_k0", round_key, KEY_A1);
    key_in = KEY_ALT;
    n = 0;
    while (!(rk_valid && round_idx == 4'd0 && round_key == KEY_ALT) && n < 40) begin
      tick();
      n++;
    end
    key_valid = 1'b0;
    chk("b2b_spacing", 128'(n), 128'(12));
    wait_idle("b2b");

    // Asynchronous reset in the middle of a schedule.
    tick();
    key_valid = 1'b1;
    key_in    = KEY_A1;
    tick();
    key_valid = 1'b0;
    n = 0;
    while (!(rk_valid && round_idx == 4'd5) && n < 40) begin
      tick();
      n++;
    end
    chk("rst_reach_idx5", 128'(round_idx), 128'(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 128'(rk_valid),  128'(0));
    chk("rst_async_ready", 128'(key_ready), 128'(1));
    chk("rst_async_idx",   128'(round_idx), 128'(0));
    tick();
    rst_n = 1'b1;
    run_check("post_rst", '0, Z_K1, '0, 1'b0, Z_K10);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key expansion that generates the eleven round keys on the fly, one per accepted handshake, directly upstream of the combined MixColumns/AddRoundKey XOR network. It captures a 128-bit cipher key, presents round key 0, and on each consumer acceptance replaces it with the next round key. No key RAM is kept. Throughput is one round key per cycle when the consumer never stalls.

## Interface
- No parameters. The block is fixed to AES-128: 10 rounds, Nk = 4.
- clk  in  1  Single clock. Rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- key_valid  in  1  key_in is valid.
- key_in  in  128  Cipher key. Byte 0 is [127:120]; byte k is [127-8k:120-8k]. Word w0 is [127:96].
- key_ready  out  1  Block is idle and will accept a key.
- rk_valid  out  1  round_key, round_idx and rk_last are valid.
- rk_ready  in  1  Consumer accepts the current round key.
- round_key  out  128  Current round key, same byte order as key_in.
- round_idx  out  4  Index of the current round key, 0..10.
- rk_last  out  1  High while round_idx == 10 and rk_valid == 1.

## Operation
- State machine has two states: IDLE and RUN. key_ready = (state == IDLE).
- IDLE:
  - On key_valid && key_ready: round_key <= key_in, round_idx <= 0, rcon <= 8'h01, rk_valid <= 1, go to RUN.
  - key_valid while not in IDLE is ignored and is not queued.
- RUN with rk_valid && rk_ready && round_idx < 10:
  - round_key <= next_key, round_idx <= round_idx + 1, rcon <= xtime(rcon). rk_valid stays 1.
- RUN with rk_valid && rk_ready && round_idx == 10:
  - rk_valid <= 0, go to IDLE. round_key and round_idx hold their last values.
- RUN with rk_ready low: all outputs hold stable. Nothing is recomputed or advanced.
- next_key is combinational from the round_key and rcon registers:
  - Current words w0..w3, w3 = [31:0].
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord uses four instances of the shared combinational forward S-box aes_sbox (8-bit in, 8-bit out).
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2; next_key = {n0,n1,n2,n3}.
- rcon is an 8-bit register. xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
- rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- The consumer applies round_key directly as the AddRoundKey operand for round round_idx. Key 0 is the initial whitening key. Key 10 is used by the final round, which has no MixColumns.

## Timing
- Reset values (applied asynchronously on rst_n low):
  - state IDLE, so key_ready = 1.
  - rk_valid 0, rk_last 0.
  - round_key 128'h0, round_idx 0, rcon 8'h01.
- Latency: key accepted at edge N, so round key 0 is valid after edge N (visible in cycle N+1).
- Each rk handshake at edge M presents the next key in cycle M+1. With rk_ready held high, keys 0..10 appear in 11 consecutive cycles.
- key_ready is reasserted in the cycle after key 10 is accepted. A new key can be captured at that edge, so the minimum key-to-key spacing is 12 cycles.
- There is no combinational path from key_valid or rk_ready to any output. key_ready, rk_valid and rk_last are decoded from registers only.
- Reset mid-operation:
  - Asserting rst_n low in RUN immediately drops rk_valid and returns the block to IDLE.
  - No partial schedule resumes after reset is released.
- Simultaneous key_valid and the final rk handshake: the key is not accepted, because key_ready is 0 in that cycle.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready tied to 1 -> expected keys:
  - idx0 = key.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx2 = f2c295f27a96b9435935807a7359f67f.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last = 1.
  - rk_valid runs for 11 consecutive cycles, then key_ready = 1.
- All-zero key -> idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Random rk_ready stalls, 50% duty, on the A.1 key -> identical key sequence. Outputs are stable on every stalled cycle and no index is skipped or repeated.
- key_valid pulsed with a different key during RUN -> it is ignored and the original schedule completes unchanged.
- Back-to-back keys: second key presented with key_valid held high -> it is captured in the first cycle key_ready = 1, and its idx0 appears 12 cycles after the first key's idx0.
- rst_n pulsed low at idx5 -> rk_valid = 0 and key_ready = 1 immediately (asynchronously). A new key afterward starts at idx0 with rcon 01.
